spi_req_arbiter: RTL and testbench
==================================

// Module: spi_req_arbiter
// PURPOSE
//  Shares the single SPI master/slave link (spitop) between NREQ requesters.
//  Round-robin arbitration picks a requester and loads its byte onto p_dat.
//  It pulses tx_en, then waits for the link's tx_done and returns rcvd_p_dat
//  tagged with the requester id. One transfer is in flight at a time.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  DW       8   data width; must match the link byte width
//  TMO_CYC  256 clk cycles allowed in WAIT before timeout (SPI_ARB_TIMEOUT_EN only)
// PORTS
//  clk        in   1        system clock; also drives the link master
//  rst        in   1        synchronous, active-low reset
//  req        in   NREQ     per-requester request; held until its grant bit pulses
//  req_dat    in   NREQ*DW  request bytes; requester i uses bits [i*DW +: DW]
//  grant      out  NREQ     one-hot, 1-cycle pulse when req_dat[i] is captured
//  p_dat      out  DW       byte to link master; stable from LAUNCH to end of WAIT
//  tx_en      out  1        1-cycle start pulse to link master
//  tx_done    in   1        link slave done level (sclk domain)
//  rcvd_p_dat in   DW       link slave received byte
//  rsp_valid  out  1        1-cycle pulse: response available
//  rsp_dat    out  DW       received byte (0 on timeout)
//  rsp_id     out  log2(NREQ) index of the serviced requester
//  rsp_err    out  1        qualifies rsp_valid: 1 = timeout
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst==0 at posedge clk):
//   - State goes to IDLE; RR pointer goes to 0; sync flops are cleared.
//   - All outputs go to 0. Any in-flight transfer is abandoned and no rsp is issued.
//  tx_done input:
//   - Passes through a 2-flop synchronizer into the clk domain.
//   - Completion is the rising edge of the synchronized signal.
//   - A rising edge is ignored outside WAIT.
//  FSM IDLE -> GRANT -> LAUNCH -> WAIT -> RESP -> IDLE:
//   IDLE:   if |req, select the first set bit at or after ptr, wrapping
//           NREQ-1 -> 0; go to GRANT. Otherwise stay.
//   GRANT:  grant[sel]=1 for 1 cycle; capture req_dat[sel] into p_dat and
//           sel into id reg; set ptr = (sel+1) mod NREQ; go to LAUNCH.
//   LAUNCH: tx_en=1 for exactly 1 cycle; clear timeout counter; go to WAIT.
//   WAIT:   on synchronized tx_done rising edge, capture rcvd_p_dat and set
//           err=0; go to RESP.
//   RESP:   rsp_valid=1 for 1 cycle with rsp_dat, rsp_id, rsp_err; go to IDLE.
//  Timing:
//   - Min latency from req to grant: 2 cycles (IDLE sample, then GRANT).
//   - Back-to-back service: after RESP, the next IDLE cycle arbitrates immediately.
//   - Dropping req before grant withdraws the request. This is legal only
//     while in IDLE; a sampled request is always serviced.
//   - Simultaneous requests: strict RR order. No requester waits more than
//     NREQ-1 transfers.
//   - A req[sel] still high after its grant counts as a new request.
//   - rsp_id width is $clog2(NREQ). NREQ=2 gives width 1.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//   - WAIT has an 8..16-bit counter sized to TMO_CYC.
//   - If no tx_done edge arrives by count TMO_CYC-1, go to RESP with
//     rsp_err=1 and rsp_dat=0.
//   - An edge on the same cycle as expiry counts as success.
//  SPI_ARB_TIMEOUT_EN undefined:
//   - No counter; WAIT exits only on tx_done and rsp_err is tied to 0.
// TESTING
//  1 Reset: hold rst=0 3 cycles with req=4'hF -> grant, tx_en, rsp_valid, busy,
//    p_dat all 0; ptr=0.
//  2 Single: req=4'b0100, req_dat[2]=8'hA5, link loopback ->
//    grant=4'b0100 at cycle 2, tx_en 1 pulse, rsp_valid with rsp_dat=8'hA5,
//    rsp_id=2, rsp_err=0.
//  3 RR fairness: req=4'hF held, data 11/22/33/44 -> rsp_id order 0,1,2,3,0;
//    exactly one tx_en per response.
//  4 Wrap: after servicing id3, req=4'b1001 -> id0 granted next, then id3.
//  5 Timeout (macro on, TMO_CYC=16): tx_done stuck 0 ->
//    rsp_valid 16 cycles after LAUNCH with rsp_err=1, rsp_dat=0; then next
//    request served normally.
//  6 Mid-op reset: assert rst=0 in WAIT -> no rsp_valid; busy=0 next cycle;
//    a stale tx_done edge after reset is ignored.

Source files
------------

// File: rtl/spi_req_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_req_arbiter_if                                            |
// | Purpose  : Requester, link and response signals of spi_req_arbiter.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface spi_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_dat;
    logic [NREQ-1:0]    grant;
    logic [DW-1:0]      p_dat;
    logic               tx_en;
    logic               tx_done;
    logic [DW-1:0]      rcvd_p_dat;
    logic               rsp_valid;
    logic [DW-1:0]      rsp_dat;
    logic [IW-1:0]      rsp_id;
    logic               rsp_err;
    logic               busy;

    // master: the arbiter; slave: requesters plus the SPI link
    modport master (
        input  req, req_dat, tx_done, rcvd_p_dat,
        output grant, p_dat, tx_en, rsp_valid, rsp_dat, rsp_id, rsp_err, busy
    );
    modport slave (
        output req, req_dat, tx_done, rcvd_p_dat,
        input  grant, p_dat, tx_en, rsp_valid, rsp_dat, rsp_id, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_req_arbiter                                               |
// | Purpose  : Round-robin sharing of one SPI link among NREQ requesters.    |
// |            Optional WAIT timeout enabled by macro SPI_ARB_TIMEOUT_EN.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spi_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TMO_CYC = 256
) (
    input  wire logic          clk,
    input  wire logic          rst,
    spi_req_arbiter_if.master  bus
);
    localparam int c_IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [c_IW-1:0] r_ptr_q, w_ptr_d;
    logic [c_IW-1:0] r_sel_q, w_sel_d;
    logic [c_IW-1:0] w_rr_sel;
    logic            w_rr_hit;
    logic [2:0]      r_sync_q, w_sync_d;
    logic            w_done_rise;
    logic [NREQ-1:0] r_grant_q, w_grant_d;
    logic [DW-1:0]   r_p_dat_q, w_p_dat_d;
    logic [DW-1:0]   r_rsp_dat_q, w_rsp_dat_d;
    logic            r_tx_en_q, w_tx_en_d;
    logic            r_rsp_valid_q, w_rsp_valid_d;
    logic            r_busy_q, w_busy_d;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int c_CW_RAW = $clog2(TMO_CYC);
    localparam int c_CW     = (c_CW_RAW < 8) ? 8 : ((c_CW_RAW > 16) ? 16 : c_CW_RAW);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TMO_CYC - 1);

    logic [c_CW-1:0] r_cnt_q, w_cnt_d;
    logic            r_err_q, w_err_d;
`else
    logic            w_tmo_unused;
    assign w_tmo_unused = (TMO_CYC > 0);
`endif

    // [0],[1] synchronise tx_done; [2] holds the previous synchronised value
    assign w_sync_d    = {r_sync_q[1:0], bus.tx_done};
    assign w_done_rise = r_sync_q[1] & ~r_sync_q[2];

    // First set request at or after the pointer, wrapping at NREQ-1
    always_comb begin
        int idx;
        w_rr_hit = 1'b0;
        w_rr_sel = '0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req[c_IW'(idx)]) begin
                w_rr_hit = 1'b1;
                w_rr_sel = c_IW'(idx);
            end
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_ptr_d     = r_ptr_q;
        w_sel_d     = r_sel_q;
        w_grant_d   = '0;
        w_p_dat_d   = r_p_dat_q;
        w_rsp_dat_d = r_rsp_dat_q;
`ifdef SPI_ARB_TIMEOUT_EN
        w_cnt_d     = '0;
        w_err_d     = r_err_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                if (w_rr_hit) begin
                    w_sel_d   = w_rr_sel;
                    w_grant_d = NREQ'(1) << w_rr_sel;
                    w_state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (r_sel_q == c_IW'(i)) w_p_dat_d = bus.req_dat[i*DW +: DW];
                end
                w_ptr_d   = (r_sel_q == c_IW'(NREQ - 1)) ? '0 : r_sel_q + 1'b1;
                w_state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
`ifdef SPI_ARB_TIMEOUT_EN
                // Counter holds cycles elapsed since LAUNCH
                w_cnt_d   = r_cnt_q + 1'b1;
`endif
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
                w_cnt_d = r_cnt_q + 1'b1;
`endif
                if (w_done_rise) begin
                    w_rsp_dat_d = bus.rcvd_p_dat;
`ifdef SPI_ARB_TIMEOUT_EN
                    w_err_d     = 1'b0;
`endif
                    w_state_d   = S_RESP;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (r_cnt_q == c_TMO_LAST) begin
                    w_rsp_dat_d = '0;
                    w_err_d     = 1'b1;
                    w_state_d   = S_RESP;
                end
`endif
            end
            S_RESP:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
        w_tx_en_d     = (w_state_d == S_LAUNCH);
        w_rsp_valid_d = (w_state_d == S_RESP);
        w_busy_d      = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q     <= S_IDLE;
            r_ptr_q       <= '0;
            r_sel_q       <= '0;
            r_sync_q      <= '0;
            r_grant_q     <= '0;
            r_p_dat_q     <= '0;
            r_rsp_dat_q   <= '0;
            r_tx_en_q     <= 1'b0;
            r_rsp_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_cnt_q       <= '0;
            r_err_q       <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_sel_q       <= w_sel_d;
            r_sync_q      <= w_sync_d;
            r_grant_q     <= w_grant_d;
            r_p_dat_q     <= w_p_dat_d;
            r_rsp_dat_q   <= w_rsp_dat_d;
            r_tx_en_q     <= w_tx_en_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_busy_q      <= w_busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
            r_cnt_q       <= w_cnt_d;
            r_err_q       <= w_err_d;
`endif
        end
    end

    assign bus.grant     = r_grant_q;
    assign bus.p_dat     = r_p_dat_q;
    assign bus.tx_en     = r_tx_en_q;
    assign bus.rsp_valid = r_rsp_valid_q;
    assign bus.rsp_dat   = r_rsp_dat_q;
    assign bus.rsp_id    = r_sel_q;
    assign bus.busy      = r_busy_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign bus.rsp_err   = r_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_spi_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_req_arbiter                                            |
// | Purpose  : Directed scoreboard bench for spi_req_arbiter with a          |
// |            loopback SPI link model.                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spi_req_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_req_arbiter_if #(.NREQ(4), .DW(8)) bus ();

    spi_req_arbiter #(.NREQ(4), .DW(8), .TMO_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] dat;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   tx_cnt = 0;
    int   exp_tx = 0;
    logic link_on    = 1'b1;
    logic link_done  = 1'b0;
    logic stale_done = 1'b0;

    assign bus.tx_done = link_done | stale_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_dat(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        bus.req_dat = {d3, d2, d1, d0};
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic e);
        rsp_t r;
        r.id  = 2'(id);
        r.dat = d;
        r.err = e;
        exp_q.push_back(r);
    endtask

    // Waits for the next grant pulse; optionally drops the granted request bit
    task automatic serve(input logic [3:0] exp_g, input logic drop, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.grant === 4'b0 && waited < 60);
        chk("grant", 32'(bus.grant), 32'(exp_g));
        exp_tx++;
        if (drop) bus.req = bus.req & ~bus.grant;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_done", 32'(exp_q.size() == 0 && bus.busy === 1'b0), 32'd1);
        chk("tx_en_count", tx_cnt, exp_tx);
    endtask

    task automatic wait_tx_en();
        int w;
        w = 0;
        while (bus.tx_en !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("tx_en_seen", 32'(bus.tx_en), 32'd1);
    endtask

    // Loopback link: echoes p_dat and raises tx_done a few cycles after tx_en
    initial begin
        bus.rcvd_p_dat = '0;
        forever begin
            @(negedge clk);
            if (bus.tx_en === 1'b1 && link_on) begin
                repeat (3) @(negedge clk);
                bus.rcvd_p_dat = bus.p_dat;
                link_done      = 1'b1;
                repeat (3) @(negedge clk);
                link_done      = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_en === 1'b1) tx_cnt++;
        end
    end

    // Scoreboard monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got id=%0d dat=%0h err=%0b, none expected (t=%0t)",
                             bus.rsp_id, bus.rsp_dat, bus.rsp_err, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id",  32'(bus.rsp_id),  32'(e.id));
                    chk("rsp_dat", 32'(bus.rsp_dat), 32'(e.dat));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        int w;
        int cyc;
        bus.req = 4'hF;
        set_dat(8'h11, 8'h22, 8'h33, 8'h44);

        // Reset held with all requests pending
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs",
                32'({bus.grant, bus.tx_en, bus.rsp_valid, bus.busy, bus.p_dat}), 32'd0);
        end

        // Round-robin with all requests held; pointer starts at 0
        push(0, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(2, 8'h33, 1'b0);
        push(3, 8'h44, 1'b0); push(0, 8'h11, 1'b0);
        rst = 1'b1;
        serve(4'b0001, 1'b0, w);
        serve(4'b0010, 1'b0, w);
        serve(4'b0100, 1'b0, w);
        serve(4'b1000, 1'b0, w);
        serve(4'b0001, 1'b0, w);
        bus.req = 4'b0000;
        drain();

        // Single request, grant one cycle after the IDLE sample
        set_dat(8'h00, 8'h00, 8'hA5, 8'h00);
        push(2, 8'hA5, 1'b0);
        bus.req = 4'b0100;
        serve(4'b0100, 1'b1, w);
        chk("grant_latency", w, 1);
        drain();

        // Wrap: service id3, then id0 precedes id3
        set_dat(8'hC0, 8'h00, 8'h00, 8'h3C);
        push(3, 8'h3C, 1'b0);
        bus.req = 4'b1000;
        serve(4'b1000, 1'b1, w);
        drain();
        set_dat(8'hC0, 8'h00, 8'h00, 8'hC3);
        push(0, 8'hC0, 1'b0); push(3, 8'hC3, 1'b0);
        bus.req = 4'b1001;
        serve(4'b0001, 1'b1, w);
        serve(4'b1000, 1'b1, w);
        drain();

        // Reset during WAIT: transfer abandoned, stale done edge ignored
        link_on = 1'b0;
        set_dat(8'h00, 8'h5A, 8'h00, 8'h00);
        bus.req = 4'b0010;
        serve(4'b0010, 1'b1, w);
        wait_tx_en();
        repeat (3) @(negedge clk);
        chk("busy_in_wait", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        stale_done = 1'b1;
        repeat (8) @(negedge clk);
        chk("stale_edge_busy", 32'(bus.busy), 32'd0);
        stale_done = 1'b0;
        repeat (4) @(negedge clk);
        link_on = 1'b1;

        // Pointer back at 0 after reset
        set_dat(8'hE0, 8'hE1, 8'h00, 8'h00);
        push(0, 8'hE0, 1'b0); push(1, 8'hE1, 1'b0);
        bus.req = 4'b0011;
        serve(4'b0001, 1'b1, w);
        serve(4'b0010, 1'b1, w);
        drain();

`ifdef SPI_ARB_TIMEOUT_EN
        // Timeout with tx_done stuck low, then a normal transfer
        link_on = 1'b0;
        set_dat(8'h99, 8'h00, 8'h77, 8'h00);
        push(2, 8'h00, 1'b1);
        bus.req = 4'b0100;
        serve(4'b0100, 1'b1, w);
        wait_tx_en();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.rsp_valid !== 1'b1 && cyc < 40);
        chk("timeout_latency", cyc, 16);
        link_on = 1'b1;
        drain();
        push(0, 8'h99, 1'b0);
        bus.req = 4'b0001;
        serve(4'b0001, 1'b1, w);
        drain();
`else
        cyc = 0;
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
